vid_field_arbiter: RTL and testbench

//  Packet-level round-robin arbiter that shares one Avalon-ST video consumer
//  (the deinterlacer) between two video sources. Grants a source for a

---
 rtl/vid_field_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_vid_field_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vid_field_arbiter.sv
// vid_field_arbiter
//   Packet-level round-robin arbiter that lets two Avalon-ST video sources
//   share one consumer (the deinterlacer). A source keeps the grant for a
//   whole frame transaction: a control packet (type 0xF) followed by a video
//   packet (type 0x0). Data path is a zero-latency combinational mux; grant,
//   state, counters and the watchdog are registered. A watchdog revokes a grant
//   stuck between the control packet and the video packet.
//
// Ports
//   clock, reset            system clock, synchronous active-low reset
//   din0_* / din1_*         source beats in (data/valid/sop/eop), ready out
//   dout_*                  beats to the consumer (data/valid/sop/eop), ready in
//   grant                   one-hot current owner, 2'b00 = none
//   frame_cnt0/frame_cnt1   video packets forwarded per source (wrapping)
//   timeout_err             one-cycle pulse when the watchdog fires
module vid_field_arbiter #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] din0_data,
  input  logic              din0_valid,
  input  logic              din0_startofpacket,
  input  logic              din0_endofpacket,
  output logic              din0_ready,
  input  logic [DATA_W-1:0] din1_data,
  input  logic              din1_valid,
  input  logic              din1_startofpacket,
  input  logic              din1_endofpacket,
  output logic              din1_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_valid,
  output logic              dout_startofpacket,
  output logic              dout_endofpacket,
  input  logic              dout_ready,
  output logic [1:0]        grant,
  output logic [15:0]       frame_cnt0,
  output logic [15:0]       frame_cnt1,
  output logic              timeout_err
);

  localparam int unsigned TMR_W     = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_W     = 16;
  localparam logic [3:0]  TYPE_CTRL = 4'hF;
  localparam logic [3:0]  TYPE_VID  = 4'h0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PASS     = 2'd1,
    S_WAIT_VID = 2'd2
  } state_t;

  // Registered state
  state_t             r_state;
  logic [1:0]         r_grant;
  logic               r_last;
  logic [3:0]         r_type;
  logic [TMR_W-1:0]   r_timer;
  logic [CNT_W-1:0]   r_frame_cnt0;
  logic [CNT_W-1:0]   r_frame_cnt1;
  logic               r_timeout_err;

  // Next-state values
  state_t             w_state_nxt;
  logic [1:0]         w_grant_nxt;
  logic               w_last_nxt;
  logic [3:0]         w_type_nxt;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic [CNT_W-1:0]   w_cnt0_nxt;
  logic [CNT_W-1:0]   w_cnt1_nxt;
  logic               w_tmo_nxt;

  // Granted-port view of the inputs
  logic               w_sel;
  logic [DATA_W-1:0]  w_g_data;
  logic               w_g_valid;
  logic               w_g_sop;
  logic               w_g_eop;
  logic               w_g_ready;
  logic               w_accept;
  logic [3:0]         w_pkt_type;
  logic               w_req0;
  logic               w_req1;

  // Port 1 is selected when its grant bit is set; with no grant the mux
  // output is never used because every path below gates on state.
  assign w_sel     = r_grant[1];
  assign w_g_data  = w_sel ? din1_data          : din0_data;
  assign w_g_valid = w_sel ? din1_valid         : din0_valid;
  assign w_g_sop   = w_sel ? din1_startofpacket : din0_startofpacket;
  assign w_g_eop   = w_sel ? din1_endofpacket   : din0_endofpacket;

  assign w_req0 = din0_valid & din0_startofpacket;
  assign w_req1 = din1_valid & din1_startofpacket;

  // State and bookkeeping registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_grant       <= 2'b00;
      r_last        <= 1'b1;
      r_type        <= 4'h0;
      r_timer       <= '0;
      r_frame_cnt0  <= '0;
      r_frame_cnt1  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_last        <= w_last_nxt;
      r_type        <= w_type_nxt;
      r_timer       <= w_timer_nxt;
      r_frame_cnt0  <= w_cnt0_nxt;
      r_frame_cnt1  <= w_cnt1_nxt;
      r_timeout_err <= w_tmo_nxt;
    end
  end

  // Next-state, data mux and ready generation
  always_comb begin
    w_state_nxt        = r_state;
    w_grant_nxt        = r_grant;
    w_last_nxt         = r_last;
    w_type_nxt         = r_type;
    w_timer_nxt        = r_timer;
    w_cnt0_nxt         = r_frame_cnt0;
    w_cnt1_nxt         = r_frame_cnt1;
    w_tmo_nxt          = 1'b0;
    w_g_ready          = 1'b0;
    w_accept           = 1'b0;
    w_pkt_type         = r_type;
    din0_ready         = 1'b0;
    din1_ready         = 1'b0;
    dout_data          = '0;
    dout_valid         = 1'b0;
    dout_startofpacket = 1'b0;
    dout_endofpacket   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // Mid-packet beats are swallowed so a source can resync on its next SOP;
        // requesters are held off during the arbitration cycle.
        din0_ready = din0_valid & ~din0_startofpacket;
        din1_ready = din1_valid & ~din1_startofpacket;
        if (w_req0 && w_req1) begin
          w_grant_nxt = r_last ? 2'b01 : 2'b10;
          w_state_nxt = S_PASS;
        end else if (w_req0) begin
          w_grant_nxt = 2'b01;
          w_state_nxt = S_PASS;
        end else if (w_req1) begin
          w_grant_nxt = 2'b10;
          w_state_nxt = S_PASS;
        end
      end

      S_PASS: begin
        dout_data          = w_g_data;
        dout_valid         = w_g_valid;
        dout_startofpacket = w_g_sop;
        dout_endofpacket   = w_g_eop;
        w_g_ready          = dout_ready;
        w_accept           = w_g_valid & dout_ready;
      end

      S_WAIT_VID: begin
        if (w_g_valid && w_g_sop) begin
          dout_data          = w_g_data;
          dout_valid         = 1'b1;
          dout_startofpacket = 1'b1;
          dout_endofpacket   = w_g_eop;
          w_g_ready          = dout_ready;
          w_accept           = dout_ready;
        end else if (w_g_valid) begin
          // Stray mid-packet beat between packets: drop it.
          w_g_ready = 1'b1;
        end

        // Watchdog: counts every cycle the video SOP has not been taken.
        if (!w_accept) begin
          if (r_timer == TMR_W'(TIMEOUT - 1)) begin
            w_tmo_nxt   = 1'b1;
            w_grant_nxt = 2'b00;
            w_last_nxt  = w_sel;
            w_state_nxt = S_IDLE;
          end else begin
            w_timer_nxt = r_timer + TMR_W'(1);
          end
        end
      end

      default: begin
        w_grant_nxt = 2'b00;
        w_state_nxt = S_IDLE;
      end
    endcase

    // Accepted beat on the granted port: track packet type and boundaries.
    if (w_accept) begin
      if (w_g_sop) begin
        w_pkt_type = w_g_data[3:0];
        w_type_nxt = w_g_data[3:0];
      end
      if (w_g_eop) begin
        if (w_pkt_type == TYPE_CTRL) begin
          w_state_nxt = S_WAIT_VID;
          w_timer_nxt = '0;
        end else begin
          if (w_pkt_type == TYPE_VID) begin
            if (w_sel) w_cnt1_nxt = r_frame_cnt1 + CNT_W'(1);
            else       w_cnt0_nxt = r_frame_cnt0 + CNT_W'(1);
          end
          w_last_nxt  = w_sel;
          w_grant_nxt = 2'b00;
          w_state_nxt = S_IDLE;
        end
      end else if (w_g_sop) begin
        w_state_nxt = S_PASS;
      end
    end

    if (r_grant[0]) din0_ready = w_g_ready;
    if (r_grant[1]) din1_ready = w_g_ready;
  end

  assign grant       = r_grant;
  assign frame_cnt0  = r_frame_cnt0;
  assign frame_cnt1  = r_frame_cnt1;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_vid_field_arbiter.sv
// tb_vid_field_arbiter
//   Drives two queued Avalon-ST sources into vid_field_arbiter and checks the
//   output stream against per-source expected-beat queues, transaction order,
//   frame counts and watchdog timing derived by the bench.
module tb_vid_field_arbiter;

  localparam int unsigned DW  = 24;
  localparam int unsigned TMO = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    int            gap;
  } beat_t;

  logic          clock;
  logic          reset;
  logic [DW-1:0] din0_data, din1_data, dout_data;
  logic          din0_valid, din0_startofpacket, din0_endofpacket, din0_ready;
  logic          din1_valid, din1_startofpacket, din1_endofpacket, din1_ready;
  logic          dout_valid, dout_startofpacket, dout_endofpacket, dout_ready;
  logic [1:0]    grant;
  logic [15:0]   frame_cnt0, frame_cnt1;
  logic          timeout_err;

  vid_field_arbiter #(.DATA_W(DW), .TIMEOUT(TMO)) u_dut (
    .clock(clock), .reset(reset),
    .din0_data(din0_data), .din0_valid(din0_valid),
    .din0_startofpacket(din0_startofpacket), .din0_endofpacket(din0_endofpacket),
    .din0_ready(din0_ready),
    .din1_data(din1_data), .din1_valid(din1_valid),
    .din1_startofpacket(din1_startofpacket), .din1_endofpacket(din1_endofpacket),
    .din1_ready(din1_ready),
    .dout_data(dout_data), .dout_valid(dout_valid),
    .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
    .dout_ready(dout_ready),
    .grant(grant), .frame_cnt0(frame_cnt0), .frame_cnt1(frame_cnt1),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Source queues (what each source still has to send) and expected
  // forwarded beats per source (source beats minus deliberate junk).
  beat_t sq0[$], sq1[$], eq0[$], eq1[$];
  int    txn_q[$];
  int    total = 0;
  int    bad   = 0;
  int    owner = -1;
  logic [3:0] ptype = 4'h0;
  int    exp_cnt0 = 0, exp_cnt1 = 0;
  int    rdy_mode = 0;
  bit    expect_tmo = 0;
  bit    wd_arm = 0;
  int    wd = 0;
  int    tmo_seen = 0;
  bit    fired0, fired1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input int s, input logic [3:0] typ, input int len,
                          input int gmax, input int sgap, input bit junk);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      logic [18:0] r;
      r      = 19'($urandom);
      b.data = {1'(s), r, (i == 0) ? typ : 4'($urandom)};
      b.sop  = (i == 0) && !junk;
      b.eop  = (i == len - 1) && !junk;
      b.gap  = (i == 0) ? sgap : int'($urandom_range(0, gmax));
      if (s == 0) begin
        sq0.push_back(b);
        if (!junk) eq0.push_back(b);
      end else begin
        sq1.push_back(b);
        if (!junk) eq1.push_back(b);
      end
    end
  endtask

  task automatic push_frame(input int s, input int clen, input int vlen,
                            input int gmax, input int vgap);
    push_pkt(s, 4'hF, clen, gmax, 0, 1'b0);
    push_pkt(s, 4'h0, vlen, gmax, vgap, 1'b0);
  endtask

  // One clock: monitor/score on the falling edge, then drive after the rising edge.
  task automatic step();
    logic [25:0] got;
    beat_t e;
    int s;
    @(negedge clock);
    fired0 = din0_valid && din0_ready;
    fired1 = din1_valid && din1_ready;
    if (owner == 0 && din1_valid) chk("xready1", 32'(din1_ready), 32'(0));
    if (owner == 1 && din0_valid) chk("xready0", 32'(din0_ready), 32'(0));
    if (wd_arm) wd++;
    if (timeout_err) begin
      tmo_seen++;
      if (wd_arm) begin
        chk("tmo_lat", 32'(wd), 32'(TMO));
        chk("tmo_grant", 32'(grant), 32'(0));
        wd_arm = 0;
      end else begin
        chk("tmo_spurious", 32'(timeout_err), 32'(0));
      end
      owner = -1;
    end
    if (dout_valid && dout_ready) begin
      s   = int'(dout_data[23]);
      got = {dout_startofpacket, dout_endofpacket, dout_data};
      chk("grant_own", 32'(grant), (s == 1) ? 32'(2) : 32'(1));
      if (owner != -1 && owner != s) chk("interleave", 32'(s), 32'(owner));
      if (s == 0) begin
        if (eq0.size() == 0) chk("extra0", 32'(dout_valid), 32'(0));
        else begin
          e = eq0.pop_front();
          chk("beat0", 32'(got), 32'({e.sop, e.eop, e.data}));
        end
      end else begin
        if (eq1.size() == 0) chk("extra1", 32'(dout_valid), 32'(0));
        else begin
          e = eq1.pop_front();
          chk("beat1", 32'(got), 32'({e.sop, e.eop, e.data}));
        end
      end
      if (dout_startofpacket) begin
        if (owner == -1) begin
          owner = s;
          txn_q.push_back(s);
        end
        ptype = dout_data[3:0];
      end
      if (dout_endofpacket) begin
        if (ptype == 4'h0) begin
          if (s == 0) exp_cnt0++; else exp_cnt1++;
          owner = -1;
        end else if (ptype != 4'hF) begin
          owner = -1;
        end else if (expect_tmo) begin
          wd     = -1;
          wd_arm = 1;
        end
      end
    end
    @(posedge clock);
    #1;
    if (fired0) void'(sq0.pop_front());
    if (fired1) void'(sq1.pop_front());
    if (sq0.size() != 0 && sq0[0].gap > 0) begin
      sq0[0].gap = sq0[0].gap - 1;
      din0_valid = 1'b0;
    end else if (sq0.size() != 0) begin
      din0_valid = 1'b1;
      din0_data = sq0[0].data;
      din0_startofpacket = sq0[0].sop;
      din0_endofpacket = sq0[0].eop;
    end else begin
      din0_valid = 1'b0;
      din0_startofpacket = 1'b0;
      din0_endofpacket = 1'b0;
    end
    if (sq1.size() != 0 && sq1[0].gap > 0) begin
      sq1[0].gap = sq1[0].gap - 1;
      din1_valid = 1'b0;
    end else if (sq1.size() != 0) begin
      din1_valid = 1'b1;
      din1_data = sq1[0].data;
      din1_startofpacket = sq1[0].sop;
      din1_endofpacket = sq1[0].eop;
    end else begin
      din1_valid = 1'b0;
      din1_startofpacket = 1'b0;
      din1_endofpacket = 1'b0;
    end
    case (rdy_mode)
      1:       dout_ready = ~dout_ready;
      2:       dout_ready = ($urandom_range(0, 3) != 0);
      default: dout_ready = 1'b1;
    endcase
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((sq0.size() + sq1.size() + eq0.size() + eq1.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_left"}, 32'(sq0.size() + sq1.size() + eq0.size() + eq1.size()), 32'(0));
    repeat (2) step();
  endtask

  task automatic model_reset();
    eq0.delete();
    eq1.delete();
    owner    = -1;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    wd_arm   = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tmo0, c0, n;
    reset = 1'b0;
    din0_data = '0; din0_valid = 1'b0; din0_startofpacket = 1'b0; din0_endofpacket = 1'b0;
    din1_data = '0; din1_valid = 1'b0; din1_startofpacket = 1'b0; din1_endofpacket = 1'b0;
    dout_ready = 1'b1;
    repeat (2) step();
    reset = 1'b1;
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_cnt0", 32'(frame_cnt0), 32'(0));
    chk("rst_cnt1", 32'(frame_cnt1), 32'(0));
    chk("rst_tmo", 32'(timeout_err), 32'(0));
    chk("rst_valid", 32'(dout_valid), 32'(0));

    // Port 0 alone: control packet plus a (shortened) video packet.
    push_frame(0, 4, 64, 0, 0);
    wait_done("s1", 400);
    chk("s1_grant", 32'(grant), 32'(0));
    chk("s1_cnt0", 32'(frame_cnt0), 32'(1));
    chk("s1_idle_valid", 32'(dout_valid), 32'(0));
    chk("s1_idle_data", 32'(dout_data), 32'(0));

    // Simultaneous requests after reset alternate 0,1,0,1.
    do_reset();
    txn_q.delete();
    push_frame(0, 4, 8, 0, 0);
    push_frame(1, 4, 8, 0, 0);
    push_frame(0, 2, 5, 0, 0);
    push_frame(1, 3, 6, 0, 0);
    wait_done("s2", 400);
    chk("s2_ntxn", 32'(txn_q.size()), 32'(4));
    for (int i = 0; i < txn_q.size() && i < 4; i++)
      chk("s2_order", 32'(txn_q[i]), 32'(i % 2));
    chk("s2_cnt0", 32'(frame_cnt0), 32'(2));
    chk("s2_cnt1", 32'(frame_cnt1), 32'(2));

    // Port 1 requests while port 0 sits between control and video packets.
    txn_q.delete();
    push_frame(0, 4, 8, 0, 6);
    n = 0;
    while (eq0.size() > 8 && n < 100) begin step(); n++; end
    push_frame(1, 2, 4, 0, 0);
    wait_done("s3", 400);
    chk("s3_ntxn", 32'(txn_q.size()), 32'(2));
    if (txn_q.size() == 2) begin
      chk("s3_first", 32'(txn_q[0]), 32'(0));
      chk("s3_second", 32'(txn_q[1]), 32'(1));
    end

    // Control packet with no video: watchdog fires; junk beats are dropped.
    expect_tmo = 1;
    tmo0 = tmo_seen;
    c0 = exp_cnt0;
    push_pkt(0, 4'hF, 4, 0, 0, 1'b0);
    push_pkt(0, 4'h0, 2, 0, 3, 1'b1);
    n = 0;
    while (tmo_seen == tmo0 && n < 80) begin step(); n++; end
    chk("s4_tmo_hit", 32'(tmo_seen - tmo0), 32'(1));
    step();
    chk("s4_pulse", 32'(timeout_err), 32'(0));
    chk("s4_grant", 32'(grant), 32'(0));
    chk("s4_cnt0", 32'(frame_cnt0), 32'(c0));
    chk("s4_drain", 32'(sq0.size()), 32'(0));
    expect_tmo = 0;

    // Back-pressure toggling 1010 during a frame.
    rdy_mode = 1;
    push_frame(0, 4, 32, 0, 0);
    wait_done("s5", 400);
    rdy_mode = 0;
    chk("s5_cnt0", 32'(frame_cnt0), 32'(exp_cnt0));

    // Reset mid-video; leftover beats must be drained, next SOP arbitrates.
    push_frame(0, 4, 4, 0, 0);
    push_frame(0, 4, 40, 0, 0);
    n = 0;
    while (eq0.size() > 20 && n < 300) begin step(); n++; end
    chk("s6_pre_cnt0", 32'(frame_cnt0 != 16'd0), 32'(1));
    do_reset();
    chk("s6_grant", 32'(grant), 32'(0));
    chk("s6_cnt0", 32'(frame_cnt0), 32'(0));
    chk("s6_cnt1", 32'(frame_cnt1), 32'(0));
    push_frame(0, 4, 4, 0, 0);
    wait_done("s6", 400);
    chk("s6_post_cnt0", 32'(frame_cnt0), 32'(1));

    // Random mix: frames and user packets on both ports, random gaps and ready.
    rdy_mode = 2;
    for (int k = 0; k < 16; k++) begin
      int s;
      s = int'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0)
        push_pkt(s, 4'($urandom_range(1, 14)), int'($urandom_range(1, 3)), 2, 0, 1'b0);
      else
        push_frame(s, int'($urandom_range(1, 4)), int'($urandom_range(1, 10)), 2, 0);
    end
    wait_done("s7", 3000);
    rdy_mode = 0;
    step();
    chk("s7_cnt0", 32'(frame_cnt0), 32'(exp_cnt0));
    chk("s7_cnt1", 32'(frame_cnt1), 32'(exp_cnt1));
    chk("s7_grant", 32'(grant), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
